iic_xfer_sequencer: RTL and testbench
=====================================

IIC_XFER_SEQUENCER -- requirements
Module: iic_xfer_sequencer

Interface
REQ-001 Parameter DEV_ADDR, 7'h50, 7-bit target device address placed in every address byte.
REQ-002 Parameter RETRY_MAX, 3, number of address-NACK retries (used only with IIC_SEQ_RETRY_EN).
REQ-003 CLK  input  1  sole clock; all state changes on posedge CLK.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  transaction request handshake.
REQ-006 cmd_rw  input  1  0 = write, 1 = read.
REQ-007 cmd_maddr  input  8  memory address (register pointer) sent after the device address byte.
REQ-008 cmd_len  input  4  number of data bytes (0..15).
REQ-009 wr_valid / wr_ready / wr_data  input / output / input  1 / 1 / 8  write-data stream from the user.
REQ-010 rd_valid / rd_data  output / output  1 / 8  read-data stream to the user, no backpressure.
REQ-011 done / err  output / output  1 / 1  one-cycle completion pulse; err is valid with done.
REQ-012 eng_valid / eng_ready / eng_op / eng_wdata / eng_nack_last  output / input / output / output / output  1 / 1 / 2 / 8 / 1  operation issue to the bit engine.
REQ-013 eng_done / eng_ack / eng_rdata  input / input / input  1 / 1 / 8  engine completion pulse, slave ACK seen, received byte.

Function
REQ-014 States SHALL be IDLE, START, DEVW, MADDR, WDATA, RSTART, DEVR, RDATA, STOP, FIN.
REQ-015 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready latches rw/maddr/len and moves to START on the next edge.
REQ-016 Each non-IDLE/FIN state SHALL issue exactly one engine op: eng_valid held high with stable eng_op/eng_wdata until eng_valid&&eng_ready, then low until eng_done.
REQ-017 eng_op encoding: 0 START, 1 WRITE_BYTE, 2 READ_BYTE, 3 STOP; RSTART issues START.
REQ-018 Sequence: START -> DEVW (byte {DEV_ADDR,0}) -> MADDR (cmd_maddr) -> write: WDATA x len -> STOP; read: RSTART -> DEVR (byte {DEV_ADDR,1}) -> RDATA x len -> STOP.
REQ-019 len 0 SHALL skip the data phase (write and read alike): MADDR -> STOP.
REQ-020 In WDATA, wr_ready SHALL be 1 only while waiting for a byte; the op is issued on the cycle after wr_valid&&wr_ready, with eng_wdata = captured wr_data.
REQ-021 In RDATA, eng_nack_last SHALL be 1 for the final byte only; rd_valid pulses one cycle on each eng_done with rd_data = eng_rdata.
REQ-022 eng_ack=0 on any WRITE_BYTE completion SHALL set the error flag and go directly to STOP; remaining bytes are not requested.
REQ-023 STOP completion SHALL go to FIN; FIN pulses done (with err) for one cycle and returns to IDLE.
REQ-024 Byte counter SHALL be 4 bits, decremented per data byte, and never wrap; the phase ends when it reaches 0.
REQ-025 eng_done arriving without an outstanding op SHALL be ignored.

Reset
REQ-026 RST high at any edge SHALL force IDLE and clear the error flag and counters; outputs next cycle: cmd_ready=1, all others 0.
REQ-027 Reset mid-transaction SHALL emit no STOP and no done; the engine shares RST and is reset alongside.

Configuration
REQ-028 With IIC_SEQ_RETRY_EN defined, NACK on DEVW or DEVR SHALL issue STOP and restart at START, up to RETRY_MAX retries, before reporting err; without it, the first address NACK reports err.

Structure
REQ-029 Shared package iic_pkg SHALL hold eng_op codes, the state enumeration and the R/W bit constants.
REQ-030 The natural sub-module is iic_master_bit (SCL/SDA bit engine), instantiated outside this block and connected via the eng_* ports.

Verification
REQ-031 Write maddr=8'h01, len=2, data A5,3C, all ACK -> ops START, WR A0, WR 01, WR A5, WR 3C, STOP; done=1, err=0.
REQ-032 Read maddr=8'h00, len=3, engine returns 48,65,6C -> START, WR A0, WR 00, START, WR A1, RD, RD, RD(nack_last=1), STOP; three rd_valid pulses with those values.
REQ-033 Write len=2, NACK on the first data byte -> STOP immediately, only one wr_ready handshake, done with err=1.
REQ-034 Device-address NACK: without macro -> one STOP, err=1; with macro and RETRY_MAX=3 -> four START attempts, then err=1.
REQ-035 RST asserted in the cycle after the third eng_done of a read -> next cycle IDLE, cmd_ready=1, no done, no rd_valid.
REQ-036 Read len=0 -> START, WR A0, WR maddr, STOP, done, err=0, no rd_valid.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC transfer sequencer: bit-engine op codes,
// sequencer state encoding, per-op sub-phase and R/W bit constants.
package iic_pkg;

  // Operation codes understood by the SCL/SDA bit engine
  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } eng_op_e;

  // Transaction-level states of the sequencer
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEVW,
    ST_MADDR,
    ST_WDATA,
    ST_RSTART,
    ST_DEVR,
    ST_RDATA,
    ST_STOP,
    ST_FIN
  } state_e;

  // Progress of the single engine op owned by the current state:
  // FETCH waits for a user write byte, ISSUE presents the op,
  // WAIT holds off until the engine reports completion.
  typedef enum logic [1:0] {
    PH_FETCH,
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  // Direction bit appended to the 7-bit device address
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Engine op that each state issues; IDLE/FIN report START (code 0)
  // so the op bus rests at zero when nothing is presented.
  function automatic eng_op_e op_for_state(input state_e s);
    eng_op_e op;
    op = OP_START;
    case (s)
      ST_DEVW, ST_MADDR, ST_WDATA, ST_DEVR: op = OP_WRITE;
      ST_RDATA:                             op = OP_READ;
      ST_STOP:                              op = OP_STOP;
      default:                              op = OP_START;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/iic_xfer_sequencer.sv
// IIC transfer sequencer: turns a register-style read/write command into
// the START / address / data / STOP op stream for an external bit engine.
// Optional build macro IIC_SEQ_RETRY_EN: retry a NACKed device-address byte
// (STOP, then START again) up to RETRY_MAX times before reporting an error.
module iic_xfer_sequencer
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         RETRY_MAX = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_maddr,
  input  logic [3:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       err,
  output logic       eng_valid,
  input  logic       eng_ready,
  output logic [1:0] eng_op,
  output logic [7:0] eng_wdata,
  output logic       eng_nack_last,
  input  logic       eng_done,
  input  logic       eng_ack,
  input  logic [7:0] eng_rdata
);

`ifdef IIC_SEQ_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       rw_q, rw_d;
  logic [7:0] maddr_q, maddr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_flag_q, err_flag_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic [7:0] retry_q, retry_d;
  logic       retry_pend_q, retry_pend_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       wr_ready_q, wr_ready_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       eng_valid_q, eng_valid_d;
  logic [1:0] eng_op_q, eng_op_d;
  logic [7:0] eng_wdata_q, eng_wdata_d;
  logic       eng_nack_last_q, eng_nack_last_d;

  // Next-state logic: walk the transaction one engine op at a time
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    maddr_d      = maddr_q;
    cnt_d        = cnt_q;
    err_flag_d   = err_flag_q;
    wbyte_d      = wbyte_q;
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rw_d         = cmd_rw;
          maddr_d      = cmd_maddr;
          cnt_d        = cmd_len;
          err_flag_d   = 1'b0;
          retry_d      = 8'd0;
          retry_pend_d = 1'b0;
          state_d      = ST_START;
          phase_d      = PH_ISSUE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        phase_d = PH_ISSUE;
      end
      default: begin
        case (phase_q)
          PH_FETCH: begin
            if (wr_valid && wr_ready_q) begin
              wbyte_d = wr_data;
              phase_d = PH_ISSUE;
            end
          end
          PH_ISSUE: begin
            if (eng_valid_q && eng_ready) phase_d = PH_WAIT;
          end
          default: begin
            if (eng_done) begin
              phase_d = PH_ISSUE;
              case (state_q)
                ST_START:  state_d = ST_DEVW;
                ST_RSTART: state_d = ST_DEVR;
                ST_DEVW, ST_DEVR: begin
                  if (eng_ack) begin
                    state_d = (state_q == ST_DEVW) ? ST_MADDR : ST_RDATA;
                  end else begin
                    if (RETRY_EN && (int'(retry_q) < RETRY_MAX)) begin
                      retry_d      = retry_q + 8'd1;
                      retry_pend_d = 1'b1;
                    end else begin
                      err_flag_d = 1'b1;
                    end
                    state_d = ST_STOP;
                  end
                end
                ST_MADDR: begin
                  if (!eng_ack) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_STOP;
                  end else if (cnt_q == 4'd0) begin
                    state_d = ST_STOP;
                  end else if (rw_q == RW_READ) begin
                    state_d = ST_RSTART;
                  end else begin
                    state_d = ST_WDATA;
                    phase_d = PH_FETCH;
                  end
                end
                ST_WDATA: begin
                  if (!eng_ack) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_STOP;
                  end else begin
                    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                    if (cnt_d == 4'd0) state_d = ST_STOP;
                    else               phase_d = PH_FETCH;
                  end
                end
                ST_RDATA: begin
                  cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                  if (cnt_d == 4'd0) state_d = ST_STOP;
                end
                default: begin
                  if (retry_pend_q) begin
                    retry_pend_d = 1'b0;
                    state_d      = ST_START;
                  end else begin
                    state_d = ST_FIN;
                  end
                end
              endcase
            end
          end
        endcase
      end
    endcase
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    cmd_ready_d     = (state_d == ST_IDLE);
    wr_ready_d      = (state_d == ST_WDATA) && (phase_d == PH_FETCH);
    eng_valid_d     = (state_d != ST_IDLE) && (state_d != ST_FIN) && (phase_d == PH_ISSUE);
    eng_op_d        = op_for_state(state_d);
    eng_nack_last_d = (state_d == ST_RDATA) && (cnt_d == 4'd1);
    done_d          = (state_d == ST_FIN);
    err_d           = (state_d == ST_FIN) && err_flag_d;
    rd_valid_d      = (state_q == ST_RDATA) && (phase_q == PH_WAIT) && eng_done;
    rd_data_d       = rd_valid_d ? eng_rdata : rd_data_q;
    eng_wdata_d     = 8'h00;
    case (state_d)
      ST_DEVW:  eng_wdata_d = {DEV_ADDR, RW_WRITE};
      ST_MADDR: eng_wdata_d = maddr_d;
      ST_WDATA: eng_wdata_d = wbyte_d;
      ST_DEVR:  eng_wdata_d = {DEV_ADDR, RW_READ};
      default:  eng_wdata_d = 8'h00;
    endcase
  end

  // State and registered outputs; reset abandons any transfer silently
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= ST_IDLE;
      phase_q         <= PH_ISSUE;
      rw_q            <= 1'b0;
      maddr_q         <= 8'h00;
      cnt_q           <= 4'd0;
      err_flag_q      <= 1'b0;
      wbyte_q         <= 8'h00;
      retry_q         <= 8'd0;
      retry_pend_q    <= 1'b0;
      cmd_ready_q     <= 1'b1;
      wr_ready_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= 8'h00;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      eng_valid_q     <= 1'b0;
      eng_op_q        <= 2'd0;
      eng_wdata_q     <= 8'h00;
      eng_nack_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      rw_q            <= rw_d;
      maddr_q         <= maddr_d;
      cnt_q           <= cnt_d;
      err_flag_q      <= err_flag_d;
      wbyte_q         <= wbyte_d;
      retry_q         <= retry_d;
      retry_pend_q    <= retry_pend_d;
      cmd_ready_q     <= cmd_ready_d;
      wr_ready_q      <= wr_ready_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_q       <= rd_data_d;
      done_q          <= done_d;
      err_q           <= err_d;
      eng_valid_q     <= eng_valid_d;
      eng_op_q        <= eng_op_d;
      eng_wdata_q     <= eng_wdata_d;
      eng_nack_last_q <= eng_nack_last_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign wr_ready      = wr_ready_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign done          = done_q;
  assign err           = err_q;
  assign eng_valid     = eng_valid_q;
  assign eng_op        = eng_op_q;
  assign eng_wdata     = eng_wdata_q;
  assign eng_nack_last = eng_nack_last_q;

endmodule

// File: tb/tb_iic_xfer_sequencer.sv
// Directed testbench for iic_xfer_sequencer; the bench plays the bit engine
// and the user side. Honours IIC_SEQ_RETRY_EN for the address-NACK case.
module tb_iic_xfer_sequencer;
  import iic_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_maddr = 8'h00;
  logic [3:0] cmd_len = 4'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic       err;
  logic       eng_valid;
  logic       eng_ready = 1'b0;
  logic [1:0] eng_op;
  logic [7:0] eng_wdata;
  logic       eng_nack_last;
  logic       eng_done = 1'b0;
  logic       eng_ack = 1'b0;
  logic [7:0] eng_rdata = 8'h00;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  logic last_err = 1'b0;
  logic [7:0] rd_q[$];

  iic_xfer_sequencer #(.DEV_ADDR(7'h50), .RETRY_MAX(3)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_maddr(cmd_maddr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_op(eng_op),
    .eng_wdata(eng_wdata), .eng_nack_last(eng_nack_last),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata)
  );

  always #5 CLK = ~CLK;

  // Observe pulses on the falling edge, well away from the active edge
  always @(negedge CLK) begin
    if (rd_valid === 1'b1) rd_q.push_back(rd_data);
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      last_err = err;
    end
    if (wr_valid === 1'b1 && wr_ready === 1'b1) hs_cnt = hs_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command and hold it until it is taken
  task automatic applyStimulus(input logic rw, input logic [7:0] maddr, input logic [3:0] len);
    int waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 40) begin tick(); waited++; end
    checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_rw = rw; cmd_maddr = maddr; cmd_len = len; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  // Act as the bit engine for one op: check it, accept it, complete it
  task automatic serveOp(input string tag, input logic [1:0] op, input logic [7:0] wdata,
                         input logic nack, input logic ack, input logic [7:0] rdata);
    int waited;
    waited = 0;
    while (eng_valid !== 1'b1 && waited < 40) begin tick(); waited++; end
    checkOutput({tag, "_valid"}, 32'(eng_valid), 32'd1);
    if (eng_valid !== 1'b1) return;
    checkOutput({tag, "_op"}, 32'(eng_op), 32'(op));
    if (op == OP_WRITE) checkOutput({tag, "_wdata"}, 32'(eng_wdata), 32'(wdata));
    checkOutput({tag, "_nack_last"}, 32'(eng_nack_last), 32'(nack));
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    checkOutput({tag, "_drop"}, 32'(eng_valid), 32'd0);
    tick();
    eng_done = 1'b1; eng_ack = ack; eng_rdata = rdata;
    tick();
    eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = 8'h00;
  endtask

  // Offer one user write byte and complete its handshake
  task automatic supplyWrite(input string tag, input logic [7:0] data);
    int waited;
    wr_valid = 1'b1; wr_data = data;
    waited = 0;
    while (wr_ready !== 1'b1 && waited < 40) begin tick(); waited++; end
    checkOutput({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int exp_cnt, input logic exp_err);
    int waited;
    waited = 0;
    while (done_cnt < exp_cnt && waited < 20) begin tick(); waited++; end
    checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_cnt));
    checkOutput({tag, "_err"}, 32'(last_err), 32'(exp_err));
  endtask

  initial begin
    int rd_base;
    int hs_base;
    int done_base;

    // Reset and idle state
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_eng_valid", 32'(eng_valid), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);

    // Stray engine completion while idle is ignored
    eng_done = 1'b1; eng_ack = 1'b1;
    tick();
    eng_done = 1'b0; eng_ack = 1'b0;
    tick();
    checkOutput("stray_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("stray_eng_valid", 32'(eng_valid), 32'd0);
    checkOutput("stray_done_cnt", 32'(done_cnt), 32'd0);

    // Write two bytes to register 01
    $display("[TB] write len=2");
    applyStimulus(1'b0, 8'h01, 4'd2);
    serveOp("w_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("w_devw", OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00);
    serveOp("w_maddr", OP_WRITE, 8'h01, 1'b0, 1'b1, 8'h00);
    supplyWrite("w_d0", 8'hA5);
    serveOp("w_d0", OP_WRITE, 8'hA5, 1'b0, 1'b1, 8'h00);
    supplyWrite("w_d1", 8'h3C);
    serveOp("w_d1", OP_WRITE, 8'h3C, 1'b0, 1'b1, 8'h00);
    serveOp("w_stop", OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
    waitDone("w", 1, 1'b0);

    // Read three bytes from register 00
    $display("[TB] read len=3");
    rd_base = rd_q.size();
    applyStimulus(1'b1, 8'h00, 4'd3);
    serveOp("r_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("r_devw", OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00);
    serveOp("r_maddr", OP_WRITE, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("r_rstart", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("r_devr", OP_WRITE, 8'hA1, 1'b0, 1'b1, 8'h00);
    serveOp("r_d0", OP_READ, 8'h00, 1'b0, 1'b1, 8'h48);
    serveOp("r_d1", OP_READ, 8'h00, 1'b0, 1'b1, 8'h65);
    serveOp("r_d2", OP_READ, 8'h00, 1'b1, 1'b1, 8'h6C);
    serveOp("r_stop", OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
    waitDone("r", 2, 1'b0);
    checkOutput("r_rd_count", 32'(rd_q.size() - rd_base), 32'd3);
    if (rd_q.size() - rd_base == 3) begin
      checkOutput("r_rd0", 32'(rd_q[rd_base]), 32'h48);
      checkOutput("r_rd1", 32'(rd_q[rd_base + 1]), 32'h65);
      checkOutput("r_rd2", 32'(rd_q[rd_base + 2]), 32'h6C);
    end

    // Data NACK on the first write byte aborts straight to STOP
    $display("[TB] write data nack");
    hs_base = hs_cnt;
    applyStimulus(1'b0, 8'h10, 4'd2);
    serveOp("n_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("n_devw", OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00);
    serveOp("n_maddr", OP_WRITE, 8'h10, 1'b0, 1'b1, 8'h00);
    supplyWrite("n_d0", 8'h5A);
    wr_valid = 1'b1; wr_data = 8'hC3;
    serveOp("n_d0", OP_WRITE, 8'h5A, 1'b0, 1'b0, 8'h00);
    serveOp("n_stop", OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
    waitDone("n", 3, 1'b1);
    wr_valid = 1'b0;
    checkOutput("n_handshakes", 32'(hs_cnt - hs_base), 32'd1);

    // Device address NACK
    $display("[TB] device address nack");
    applyStimulus(1'b0, 8'h22, 4'd1);
`ifdef IIC_SEQ_RETRY_EN
    for (int a = 0; a < 4; a++) begin
      serveOp("a_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
      serveOp("a_devw", OP_WRITE, 8'hA0, 1'b0, 1'b0, 8'h00);
      serveOp("a_stop", OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
    end
`else
    serveOp("a_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("a_devw", OP_WRITE, 8'hA0, 1'b0, 1'b0, 8'h00);
    serveOp("a_stop", OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
`endif
    waitDone("a", 4, 1'b1);
    checkOutput("a_idle_valid", 32'(eng_valid), 32'd0);

    // Read with zero length skips the data phase
    $display("[TB] read len=0");
    rd_base = rd_q.size();
    applyStimulus(1'b1, 8'h7E, 4'd0);
    serveOp("z_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("z_devw", OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00);
    serveOp("z_maddr", OP_WRITE, 8'h7E, 1'b0, 1'b1, 8'h00);
    serveOp("z_stop", OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00);
    waitDone("z", 5, 1'b0);
    checkOutput("z_rd_count", 32'(rd_q.size() - rd_base), 32'd0);

    // Reset right after the last read completion abandons the transfer
    $display("[TB] reset mid-read");
    applyStimulus(1'b1, 8'h00, 4'd3);
    serveOp("x_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("x_devw", OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00);
    serveOp("x_maddr", OP_WRITE, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("x_rstart", OP_START, 8'h00, 1'b0, 1'b1, 8'h00);
    serveOp("x_devr", OP_WRITE, 8'hA1, 1'b0, 1'b1, 8'h00);
    serveOp("x_d0", OP_READ, 8'h00, 1'b0, 1'b1, 8'h11);
    serveOp("x_d1", OP_READ, 8'h00, 1'b0, 1'b1, 8'h22);
    serveOp("x_d2", OP_READ, 8'h00, 1'b1, 1'b1, 8'h33);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    done_base = done_cnt;
    rd_base = rd_q.size();
    checkOutput("x_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("x_eng_valid", 32'(eng_valid), 32'd0);
    checkOutput("x_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("x_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("x_done_after", 32'(done_cnt - done_base), 32'd0);
    checkOutput("x_rd_after", 32'(rd_q.size() - rd_base), 32'd0);
    checkOutput("x_still_idle", 32'(eng_valid), 32'd0);
    checkOutput("x_total_done", 32'(done_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
